seq_subt_divider: RTL and testbench

//  Iterative restoring divider, one shift-and-subtract step per clock. Parametrised

---
 rtl/seq_subt_divider.sv | 128 ++++++++++++
 tb/tb_seq_subt_divider.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_subt_divider.sv
// Iterative restoring divider: one shift-and-subtract step per clock with a
// start/busy/done handshake. Results are registered and held until the next completion.
module seq_subt_divider #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] dvd_reg, dvd_next;
    logic [WIDTH-1:0] dvs_reg, dvs_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             dbz_reg, dbz_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             div_by_zero_reg, div_by_zero_next;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] shifted;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in WIDTH bits whenever the trial subtraction borrows.
    assign trial   = {rem_reg, dvd_reg[WIDTH-1]} - {1'b0, dvs_reg};
    assign shifted = {rem_reg[WIDTH-2:0], dvd_reg[WIDTH-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            dvd_reg         <= '0;
            dvs_reg         <= '0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            cnt_reg         <= '0;
            dbz_reg         <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            dvd_reg         <= dvd_next;
            dvs_reg         <= dvs_next;
            rem_reg         <= rem_next;
            quo_reg         <= quo_next;
            cnt_reg         <= cnt_next;
            dbz_reg         <= dbz_next;
            quotient_reg    <= quotient_next;
            remainder_reg   <= remainder_next;
            div_by_zero_reg <= div_by_zero_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        dvd_next         = dvd_reg;
        dvs_next         = dvs_reg;
        rem_next         = rem_reg;
        quo_next         = quo_reg;
        cnt_next         = cnt_reg;
        dbz_next         = dbz_reg;
        quotient_next    = quotient_reg;
        remainder_next   = remainder_reg;
        div_by_zero_next = div_by_zero_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    dvd_next   = dividend;
                    dvs_next   = divisor;
                    state_next = RUN;
                    if (divisor == '0) begin
                        // Result is known immediately; a zero count sends the
                        // next edge straight to the result transfer.
                        quo_next = '1;
                        rem_next = dividend;
                        dbz_next = 1'b1;
                        cnt_next = '0;
                    end else begin
                        quo_next = '0;
                        rem_next = '0;
                        dbz_next = 1'b0;
                        cnt_next = CW'(WIDTH);
                    end
                end
            end
            RUN: begin
                if (cnt_reg == '0) begin
                    quotient_next    = quo_reg;
                    remainder_next   = rem_reg;
                    div_by_zero_next = dbz_reg;
                    state_next       = FINISH;
                end else begin
                    rem_next = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
                    quo_next = {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
                    dvd_next = {dvd_reg[WIDTH-2:0], 1'b0};
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == FINISH);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_subt_divider.sv
// Bench for seq_subt_divider at WIDTH=6 (vector table and corner sequences) and
// WIDTH=10 (random sweep); results are checked through per-instance scoreboards.
module tb_seq_subt_divider;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start6 = 1'b0, busy6, done6, dbz6;
    logic [5:0] a6 = '0, b6 = '0, quo6, rem6;
    logic       start10 = 1'b0, busy10, done10, dbz10;
    logic [9:0] a10 = '0, b10 = '0, quo10, rem10;

    seq_subt_divider #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .dividend(a6), .divisor(b6),
        .busy(busy6), .done(done6), .quotient(quo6), .remainder(rem6),
        .div_by_zero(dbz6)
    );

    seq_subt_divider #(.WIDTH(10)) dut10 (
        .clk(clk), .rst(rst), .start(start10), .dividend(a10), .divisor(b10),
        .busy(busy10), .done(done10), .quotient(quo10), .remainder(rem10),
        .div_by_zero(dbz10)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb6[$];
    exp_t sb10[$];
    exp_t m6, m10;
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard consumers: every done pulse must match the oldest pending request.
    always @(negedge clk) begin
        if (rst === 1'b0 && done6 === 1'b1) begin
            check("w6 busy during done", busy6, 1);
            if (sb6.size() == 0) begin
                check("w6 unexpected done", 1, 0);
            end else begin
                m6 = sb6.pop_front();
                $display("w6  %0d/%0d -> q=%0d r=%0d dbz=%0d", m6.a, m6.b, quo6, rem6, dbz6);
                check("w6 quotient", quo6, m6.q);
                check("w6 remainder", rem6, m6.r);
                check("w6 div_by_zero", dbz6, m6.dbz);
            end
        end
        if (rst === 1'b0 && done10 === 1'b1) begin
            if (sb10.size() == 0) begin
                check("w10 unexpected done", 1, 0);
            end else begin
                m10 = sb10.pop_front();
                $display("w10 %0d/%0d -> q=%0d r=%0d dbz=%0d", m10.a, m10.b, quo10, rem10, dbz10);
                check("w10 quotient", quo10, m10.q);
                check("w10 remainder", rem10, m10.r);
                check("w10 div_by_zero", dbz10, m10.dbz);
                if (m10.b != 0) begin
                    check("w10 invariant", int'(quo10) * int'(m10.b) + int'(rem10), m10.a);
                    check("w10 remainder below divisor", rem10 < m10.b[9:0], 1);
                end
            end
        end
    end

    // Issues one operation and follows it to done. inject_at > 0 re-pulses start
    // (with 20/3) that many cycles after acceptance; it must be ignored.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] q, input logic [15:0] r, input logic dbz,
                          input int lat, input int inject_at);
        exp_t        e;
        logic [15:0] q_hold;
        logic        d, bz;
        logic [15:0] qo;
        bit          seen;
        e = '{a, b, q, r, dbz};
        @(negedge clk);
        q_hold = (w == 6) ? {10'b0, quo6} : {6'b0, quo10};
        if (w == 6) begin
            start6 = 1'b1; a6 = a[5:0]; b6 = b[5:0]; sb6.push_back(e);
        end else begin
            start10 = 1'b1; a10 = a[9:0]; b10 = b[9:0]; sb10.push_back(e);
        end
        seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start6 = 1'b0; start10 = 1'b0;
                a6 = 6'($urandom); b6 = 6'($urandom);
                a10 = 10'($urandom); b10 = 10'($urandom);
            end
            if (inject_at > 0 && i == inject_at) begin
                start6 = 1'b1; a6 = 6'd20; b6 = 6'd3;
            end
            if (inject_at > 0 && i == inject_at + 1) start6 = 1'b0;
            d  = (w == 6) ? done6 : done10;
            bz = (w == 6) ? busy6 : busy10;
            qo = (w == 6) ? {10'b0, quo6} : {6'b0, quo10};
            if (d) begin
                seen = 1;
                check("done latency", i, lat);
            end else begin
                check("busy while running", bz, 1);
                check("quotient held during run", qo, q_hold);
            end
        end
        if (!seen) check("done timeout", 0, 1);
    endtask

    localparam int NV = 11;
    exp_t vec[NV];

    initial begin
        vec[0]  = '{16'd45, 16'd10, 16'd4,  16'd5,  1'b0};
        vec[1]  = '{16'd63, 16'd1,  16'd63, 16'd0,  1'b0};
        vec[2]  = '{16'd9,  16'd10, 16'd0,  16'd9,  1'b0};
        vec[3]  = '{16'd63, 16'd63, 16'd1,  16'd0,  1'b0};
        vec[4]  = '{16'd0,  16'd7,  16'd0,  16'd0,  1'b0};
        vec[5]  = '{16'd5,  16'd0,  16'd63, 16'd5,  1'b1};
        vec[6]  = '{16'd20, 16'd3,  16'd6,  16'd2,  1'b0};
        vec[7]  = '{16'd62, 16'd2,  16'd31, 16'd0,  1'b0};
        vec[8]  = '{16'd17, 16'd5,  16'd3,  16'd2,  1'b0};
        vec[9]  = '{16'd0,  16'd0,  16'd63, 16'd0,  1'b1};
        vec[10] = '{16'd20, 16'd3,  16'd6,  16'd2,  1'b0};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy", busy6, 0);
        check("reset done", done6, 0);
        check("reset quotient", quo6, 0);
        check("reset remainder", rem6, 0);
        check("reset div_by_zero", dbz6, 0);
        check("reset busy w10", busy10, 0);
        rst = 1'b0;

        for (int n = 0; n < NV; n++)
            run_op(6, vec[n].a, vec[n].b, vec[n].q, vec[n].r, vec[n].dbz,
                   (vec[n].b == 0) ? 2 : 8, 0);

        // Start re-pulsed during RUN must be ignored.
        run_op(6, 16'd45, 16'd10, 16'd4, 16'd5, 1'b0, 8, 3);
        repeat (12) @(negedge clk);
        check("w6 idle after ignored start", busy6, 0);

        // Load a known result, then abort a run three cycles in.
        run_op(6, 16'd20, 16'd3, 16'd6, 16'd2, 1'b0, 8, 0);
        @(negedge clk);
        start6 = 1'b1; a6 = 6'd45; b6 = 6'd10;
        @(negedge clk);
        start6 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy6, 0);
        check("abort done", done6, 0);
        check("abort quotient", quo6, 0);
        check("abort remainder", rem6, 0);
        check("abort div_by_zero", dbz6, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("no done after abort", busy6, 0);
        run_op(6, 16'd45, 16'd10, 16'd4, 16'd5, 1'b0, 8, 0);

        for (int n = 0; n < 1000; n++) begin
            logic [15:0] a, b;
            a = 16'($urandom_range(0, 1023));
            if (n % 50 == 0)     b = 16'd0;
            else if (n % 3 == 0) b = 16'($urandom_range(1, 15));
            else                 b = 16'($urandom_range(1, 1023));
            if (b == 0) run_op(10, a, b, 16'd1023, a, 1'b1, 2, 0);
            else        run_op(10, a, b, a / b, a % b, 1'b0, 12, 0);
        end

        repeat (4) @(negedge clk);
        check("w6 scoreboard drained", sb6.size(), 0);
        check("w10 scoreboard drained", sb10.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
